// File: rtl/fetch_queue_unit.sv
// Instruction fetch queue: issues sequential fetches, queues in-order responses, handles redirects.
// Optional stall counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_queue_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_resp_valid,
  input  logic [31:0]     mem_resp_data,
  output logic            inst_valid,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  output logic [31:0]     perf_stall_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [31:0]     data_q [DEPTH];
  logic [XLEN-1:0] pc_q   [DEPTH];

  logic            req_fire, resp_acc, resp_drop, push, pop;
  logic [CntW:0]   in_flight;
  logic [XLEN-1:0] redirect_aligned;

  // Queued entries plus outstanding requests never exceed DEPTH, so pushes cannot overflow.
  assign in_flight        = {1'b0, count_q} + {1'b0, outstanding_q};
  assign mem_req_valid    = reset_n && !redirect_valid && (in_flight < (CntW + 1)'(DEPTH));
  assign mem_req_addr     = fetch_pc_q;
  assign redirect_aligned = redirect_pc & ~XLEN'(3);

  assign req_fire  = mem_req_valid && mem_req_ready;
  assign resp_acc  = mem_resp_valid && (outstanding_q != '0);
  assign resp_drop = resp_acc && (drop_cnt_q != '0);
  assign push      = resp_acc && !resp_drop && !redirect_valid;
  assign pop       = inst_valid && inst_ready;

  assign inst_valid = (count_q != '0);
  assign inst_data  = inst_valid ? data_q[head_q] : '0;
  assign inst_pc    = inst_valid ? pc_q[head_q]   : '0;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(resp_acc);
    count_d       = count_q + CntW'(push) - CntW'(pop);

    if (req_fire)  fetch_pc_d = fetch_pc_q + XLEN'(4);
    if (resp_drop) drop_cnt_d = drop_cnt_q - CntW'(1);
    if (push) begin
      tail_d    = tail_q + PtrW'(1);
      resp_pc_d = resp_pc_q + XLEN'(4);
    end
    if (pop) head_d = head_q + PtrW'(1);

    // Every request still in flight after this cycle belongs to the old stream.
    if (redirect_valid) begin
      fetch_pc_d = redirect_aligned;
      resp_pc_d  = redirect_aligned;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      drop_cnt_d = outstanding_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      data_q[tail_q] <= mem_resp_data;
      pc_q[tail_q]   <= resp_pc_q;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (!inst_valid && (perf_q != '1)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) perf_q <= '0;
    else          perf_q <= perf_d;
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule
